datapath_controller: RTL

Multi-cycle control state machine that sequences the RV32I datapath (PC controller, instruction memory, register file, ALU, RAM). It decodes the latched instruction word and the branch comparator result, and drives every datapath control strobe. It gates execution with a run input, and reports halt, illegal-instruction and retired-instruction status. It sits beside the datapath in the top level, fed by its irOut/comparatorOut outputs.

---
 rtl/riscv_ctrl_pkg.sv | 79 +++++++
 rtl/datapath_controller_if.sv | 40 ++++
 rtl/instr_class_decoder.sv | 36 +++
 rtl/datapath_controller.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle datapath controller: FSM states,
// opcodes, mux selects, access-size codes and the packed strobe bundle.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6,
        ST_TRAP    = 3'd7
    } ctrl_state_e;

    typedef enum logic [3:0] {
        CLS_ALU_R   = 4'd0,
        CLS_ALU_I   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_SYSTEM  = 4'd8,
        CLS_ILLEGAL = 4'd9
    } instr_class_e;

    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] PCSEL_PLUS4  = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_IMM    = 2'b10;
    localparam logic [1:0] PCSEL_ALU    = 2'b11;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_RAM  = 2'b01;
    localparam logic [1:0] M2R_LINK = 2'b10;
    localparam logic [1:0] M2R_IMM  = 2'b11;

    // Size codes are ordered {isByte, isHalf, isWord}
    localparam logic [2:0] SIZE_NONE = 3'b000;
    localparam logic [2:0] SIZE_BYTE = 3'b100;
    localparam logic [2:0] SIZE_HALF = 3'b010;
    localparam logic [2:0] SIZE_WORD = 3'b001;

    typedef struct packed {
        logic       ir_en;
        logic       pc_en;
        logic       reg_write;
        logic       alu_src;
        logic       ram_rd_en;
        logic       ram_wr_en;
        logic [2:0] size;
        logic [1:0] pc_select;
        logic [1:0] mem_to_reg;
        logic       branch_taken;
    } ctrl_strobes_t;

    localparam ctrl_strobes_t STROBES_OFF = 14'd0;

    function automatic logic [2:0] size_onehot(input logic [1:0] funct3_lo);
        case (funct3_lo)
            2'b00:   size_onehot = SIZE_BYTE;
            2'b01:   size_onehot = SIZE_HALF;
            2'b10:   size_onehot = SIZE_WORD;
            default: size_onehot = SIZE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/datapath_controller_if.sv
// Controller <-> datapath bundle: decode inputs from the datapath, control
// strobes and status back. slave = controller side, master = datapath side.
interface datapath_controller_if #(parameter int DWIDTH = 32);

    logic              run;
    logic [DWIDTH-1:0] irOut;
    logic              comparatorOut;

    logic              irEn;
    logic              pcEn;
    logic              regWrite;
    logic              aluSrc;
    logic              ramRdEn;
    logic              ramWrEn;
    logic              isByte;
    logic              isHalf;
    logic              isWord;
    logic [1:0]        pcSelect;
    logic [1:0]        memToReg;
    logic [2:0]        state;
    logic              halted;
    logic              illegal;
    logic              branchTaken;
    logic [DWIDTH-1:0] instret;

    modport master (
        output run, irOut, comparatorOut,
        input  irEn, pcEn, regWrite, aluSrc, ramRdEn, ramWrEn,
        input  isByte, isHalf, isWord, pcSelect, memToReg,
        input  state, halted, illegal, branchTaken, instret
    );

    modport slave (
        input  run, irOut, comparatorOut,
        output irEn, pcEn, regWrite, aluSrc, ramRdEn, ramWrEn,
        output isByte, isHalf, isWord, pcSelect, memToReg,
        output state, halted, illegal, branchTaken, instret
    );

endinterface

// File: rtl/instr_class_decoder.sv
// Combinational classifier: opcode -> instruction class, funct3[1:0] -> one-hot
// access size plus a flag telling whether that size is encodable.
module instr_class_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [1:0]   funct3_lo,
    output instr_class_e cls,
    output logic [2:0]   size,
    output logic         size_legal
);

    // Opcode classification; AUIPC and every unlisted opcode fall to illegal
    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_ALU_R:  cls = CLS_ALU_R;
            OP_ALU_I:  cls = CLS_ALU_I;
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = CLS_BRANCH;
            OP_JAL:    cls = CLS_JAL;
            OP_JALR:   cls = CLS_JALR;
            OP_LUI:    cls = CLS_LUI;
            OP_SYSTEM: cls = CLS_SYSTEM;
            default:   cls = CLS_ILLEGAL;
        endcase
    end

    // Access size; only meaningful for loads and stores
    always_comb begin
        size       = size_onehot(funct3_lo);
        size_legal = (funct3_lo != 2'b11);
    end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/mem/writeback,
// drives registered datapath strobes, and tracks halt/illegal/instret status.
module datapath_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    datapath_controller_if.slave  bus
);

    localparam logic [DWIDTH-1:0] INSTRET_ONE = {{(DWIDTH-1){1'b0}}, 1'b1};

    ctrl_state_e       state_d, state_q;
    ctrl_strobes_t     strb_d, strb_q;
    logic [DWIDTH-1:0] instret_d, instret_q;
    logic              halted_d, halted_q;
    logic              illegal_d, illegal_q;
    logic              retire_s;

    instr_class_e      cls_s;
    logic [2:0]        size_s;
    logic              size_legal_s;
    logic              unused_ir_s;

    assign unused_ir_s = ^{bus.irOut[DWIDTH-1:14], bus.irOut[11:7]};

    instr_class_decoder u_decoder (
        .opcode     (bus.irOut[6:0]),
        .funct3_lo  (bus.irOut[13:12]),
        .cls        (cls_s),
        .size       (size_s),
        .size_legal (size_legal_s)
    );

    // Next-state, retire detection, instret and sticky status flags
    always_comb begin
        state_d   = state_q;
        retire_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.run) state_d = ST_FETCH;
                else         state_d = ST_IDLE;
            end
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (cls_s)
                    CLS_SYSTEM:  state_d = ST_HALT;
                    CLS_ILLEGAL: state_d = ST_TRAP;
                    CLS_LOAD, CLS_STORE: begin
                        if (size_legal_s) state_d = ST_EXECUTE;
                        else              state_d = ST_TRAP;
                    end
                    default:     state_d = ST_EXECUTE;
                endcase
            end
            ST_EXECUTE: begin
                case (cls_s)
                    CLS_BRANCH:          retire_s = 1'b1;
                    CLS_LOAD, CLS_STORE: state_d  = ST_MEM;
                    default:             state_d  = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (cls_s == CLS_STORE) retire_s = 1'b1;
                else                    state_d  = ST_WB;
            end
            ST_WB:   retire_s = 1'b1;
            ST_HALT: state_d  = ST_HALT;
            ST_TRAP: state_d  = ST_TRAP;
            default: state_d  = ST_IDLE;
        endcase

        // run is only looked at once the current instruction has retired
        if (retire_s) begin
            state_d   = bus.run ? ST_FETCH : ST_IDLE;
            instret_d = instret_q + INSTRET_ONE;
        end else begin
            instret_d = instret_q;
        end

        halted_d  = halted_q  | (state_d == ST_HALT);
        illegal_d = illegal_q | (state_d == ST_TRAP);
    end

    // Strobes for the state being entered, so they appear registered in that state
    always_comb begin
        strb_d = STROBES_OFF;
        case (state_d)
            ST_FETCH: strb_d.ir_en = 1'b1;
            ST_EXECUTE: begin
                case (cls_s)
                    CLS_ALU_I, CLS_LOAD, CLS_STORE, CLS_JALR: strb_d.alu_src = 1'b1;
                    CLS_BRANCH: begin
                        strb_d.pc_en        = 1'b1;
                        strb_d.pc_select    = PCSEL_BRANCH;
                        strb_d.branch_taken = bus.comparatorOut;
                    end
                    default: strb_d = STROBES_OFF;
                endcase
            end
            ST_MEM: begin
                strb_d.alu_src = 1'b1;
                strb_d.size    = size_s;
                if (cls_s == CLS_STORE) begin
                    strb_d.ram_wr_en = 1'b1;
                    strb_d.pc_en     = 1'b1;
                    strb_d.pc_select = PCSEL_PLUS4;
                end else begin
                    strb_d.ram_rd_en = 1'b1;
                end
            end
            ST_WB: begin
                strb_d.reg_write = 1'b1;
                strb_d.pc_en     = 1'b1;
                case (cls_s)
                    CLS_ALU_I: strb_d.alu_src = 1'b1;
                    CLS_LOAD: begin
                        strb_d.mem_to_reg = M2R_RAM;
                        strb_d.alu_src    = 1'b1;
                        strb_d.size       = size_s;
                    end
                    CLS_JAL: begin
                        strb_d.mem_to_reg = M2R_LINK;
                        strb_d.pc_select  = PCSEL_IMM;
                    end
                    CLS_JALR: begin
                        strb_d.mem_to_reg = M2R_LINK;
                        strb_d.pc_select  = PCSEL_ALU;
                        strb_d.alu_src    = 1'b1;
                    end
                    CLS_LUI: strb_d.mem_to_reg = M2R_IMM;
                    default: strb_d.mem_to_reg = M2R_ALU;
                endcase
            end
            default: strb_d = STROBES_OFF;
        endcase
    end

    // State, strobe and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            strb_q    <= STROBES_OFF;
            instret_q <= {DWIDTH{1'b0}};
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            strb_q    <= strb_d;
            instret_q <= instret_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.irEn        = strb_q.ir_en;
    assign bus.pcEn        = strb_q.pc_en;
    assign bus.regWrite    = strb_q.reg_write;
    assign bus.aluSrc      = strb_q.alu_src;
    assign bus.ramRdEn     = strb_q.ram_rd_en;
    assign bus.ramWrEn     = strb_q.ram_wr_en;
    assign bus.isByte      = strb_q.size[2];
    assign bus.isHalf      = strb_q.size[1];
    assign bus.isWord      = strb_q.size[0];
    assign bus.pcSelect    = strb_q.pc_select;
    assign bus.memToReg    = strb_q.mem_to_reg;
    assign bus.branchTaken = strb_q.branch_taken;
    assign bus.state       = state_q;
    assign bus.halted      = halted_q;
    assign bus.illegal     = illegal_q;
    assign bus.instret     = instret_q;

endmodule
